// File: rtl/cnn_mac_pkg.sv
// Shared widths and the signed-saturation helper used across the CNN MAC datapath.
package cnn_mac_pkg;
  localparam int DEF_DIN0_WIDTH = 14;
  localparam int DEF_DIN1_WIDTH = 6;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_DOUT_WIDTH = 20;

  typedef struct packed {
    logic [63:0] val;
    logic        clip;
  } sat_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  localparam int DEF_PW = prod_width(DEF_DIN0_WIDTH, DEF_DIN1_WIDTH);

  // Clamp v into the signed range of a w-bit value; clip flags that clamping happened.
  function automatic sat_t sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] vmax;
    logic signed [63:0] vmin;
    sat_t r;
    vmax = (64'sd1 <<< (w - 1)) - 64'sd1;
    vmin = -vmax - 64'sd1;
    r.clip = 1'b1;
    if (v > vmax) begin
      r.val = vmax;
    end else if (v < vmin) begin
      r.val = vmin;
    end else begin
      r.val  = v;
      r.clip = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Operand register, multiplier and NUM_STAGE-deep product pipeline with valid/first/last sideband.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int NUM_STAGE = 2,
  parameter int A_WIDTH   = DEF_DIN0_WIDTH,
  parameter int B_WIDTH   = DEF_DIN1_WIDTH,
  parameter int B_SIGNED  = 0,
  parameter int PW        = DEF_PW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  output logic                 p_valid,
  output logic                 p_first,
  output logic                 p_last,
  output logic signed [PW-1:0] p
);
  logic signed [B_WIDTH:0] b_ext;
  logic [NUM_STAGE-1:0]    v_q;
  logic [NUM_STAGE-1:0]    f_q;
  logic [NUM_STAGE-1:0]    l_q;

  // One extra bit lets an unsigned weight ride through a signed multiply.
  assign b_ext = (B_SIGNED != 0) ? $signed({din1[B_WIDTH-1], din1}) : $signed({1'b0, din1});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else if (ce) begin
      v_q[0] <= in_valid;
      f_q[0] <= in_first;
      l_q[0] <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign p_valid = v_q[NUM_STAGE-1];
  assign p_first = f_q[NUM_STAGE-1];
  assign p_last  = l_q[NUM_STAGE-1];

  if (NUM_STAGE == 1) begin : g_single
    logic signed [PW-1:0] p_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        p_q <= '0;
      end else if (ce) begin
        p_q <= PW'($signed(din0)) * PW'(b_ext);
      end
    end
    assign p = p_q;
  end else begin : g_multi
    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH:0]   b_q;
    logic signed [PW-1:0]      p_q [NUM_STAGE-1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        for (int i = 0; i < NUM_STAGE - 1; i++) p_q[i] <= '0;
      end else if (ce) begin
        a_q    <= din0;
        b_q    <= b_ext;
        p_q[0] <= PW'(a_q) * PW'(b_q);
        for (int i = 1; i < NUM_STAGE - 1; i++) p_q[i] <= p_q[i-1];
      end
    end
    assign p = p_q[NUM_STAGE-2];
  end
endmodule

// File: rtl/cnn_mac_pipe_sat.sv
// CNN MAC: pipelined activation x weight product, windowed clamped accumulation, saturated result per window.
module cnn_mac_pipe_sat
  import cnn_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = DEF_DIN0_WIDTH,
  parameter int din1_WIDTH = DEF_DIN1_WIDTH,
  parameter int B_SIGNED   = 0,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int dout_WIDTH = DEF_DOUT_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [din0_WIDTH-1:0]        din0,
  input  logic [din1_WIDTH-1:0]        din1,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);
  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);

  logic                         m_valid;
  logic                         m_first;
  logic                         m_last;
  logic signed [PW-1:0]         m_p;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic                         ovf_acc;
  logic                         ovf_acc_d;
  logic                         ovf_d;
  logic signed [dout_WIDTH-1:0] dout_d;
  logic signed [63:0]           sum;
  sat_t                         sat_acc;
  sat_t                         sat_out;

  cnn_mac_mul_pipe #(
    .NUM_STAGE(NUM_STAGE),
    .A_WIDTH  (din0_WIDTH),
    .B_WIDTH  (din1_WIDTH),
    .B_SIGNED (B_SIGNED),
    .PW       (PW)
  ) u_mul (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .ce      (ce),
    .in_valid(in_valid),
    .in_first(in_first),
    .in_last (in_last),
    .din0    (din0),
    .din1    (din1),
    .p_valid (m_valid),
    .p_first (m_first),
    .p_last  (m_last),
    .p       (m_p)
  );

  // A first beat restarts both the sum and the sticky overflow before this beat is added.
  always_comb begin
    sum       = (m_first ? 64'sd0 : 64'(acc)) + 64'(m_p);
    sat_acc   = sat_signed(sum, ACC_WIDTH);
    acc_d     = ACC_WIDTH'(sat_acc.val);
    ovf_acc_d = (m_first ? 1'b0 : ovf_acc) | sat_acc.clip;
    sat_out   = sat_signed(64'(acc_d), dout_WIDTH);
    dout_d    = dout_WIDTH'(sat_out.val);
    ovf_d     = ovf_acc_d | sat_out.clip;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= m_valid & m_last;
      if (m_valid) begin
        acc     <= acc_d;
        ovf_acc <= ovf_acc_d;
        if (m_last) begin
          dout <= dout_d;
          ovf  <= ovf_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// Bench for cnn_mac_pipe_sat: unsigned-weight (2 stages) and signed-weight (3 stages) instances on shared inputs.
module tb_cnn_mac_pipe_sat;
  localparam int NS0  = 2;
  localparam int NS1  = 3;
  localparam int AW   = 14;
  localparam int BW   = 6;
  localparam int ACCW = 24;
  localparam int DW   = 20;
  localparam longint AMAX = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint AMIN = -AMAX - 1;
  localparam longint DMAX = (longint'(1) << (DW - 1)) - 1;
  localparam longint DMIN = -DMAX - 1;

  logic ap_clk = 1'b0;
  logic ap_rst_n, ce, in_valid, in_first, in_last;
  logic [AW-1:0] din0;
  logic [BW-1:0] din1;
  logic ov0, ov1, of0, of1;
  logic signed [DW-1:0] do0, do1;
  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_mac_pipe_sat #(.ID(0), .NUM_STAGE(NS0), .din0_WIDTH(AW), .din1_WIDTH(BW), .B_SIGNED(0),
                     .ACC_WIDTH(ACCW), .dout_WIDTH(DW)) dut_u (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov0), .dout(do0), .ovf(of0));

  cnn_mac_pipe_sat #(.ID(1), .NUM_STAGE(NS1), .din0_WIDTH(AW), .din1_WIDTH(BW), .B_SIGNED(1),
                     .ACC_WIDTH(ACCW), .dout_WIDTH(DW)) dut_s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov1), .dout(do1), .ovf(of1));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic beat(input int a, input int b, input bit f, input bit l);
    in_valid = 1'b1;
    din0     = AW'(a);
    din1     = BW'(b);
    in_first = f;
    in_last  = l;
  endtask

  // Reference model: window sums in plain integers, results scheduled by ce-cycle count.
  longint m_acc[2];
  bit     m_ovfa[2];
  bit     e_v[2];
  longint e_d[2];
  bit     e_o[2];
  longint f_d[2][8];
  bit     f_o[2][8];
  longint f_due[2][8];
  int     f_wr[2];
  int     f_rd[2];
  longint ce_cnt = 0;
  bit     model_on = 1'b0;
  longint mp, mw, md;
  bit     mo;

  always @(posedge ap_clk) begin
    if (ap_rst_n && ce) ce_cnt++;
    for (int k = 0; k < 2; k++) begin
      if (!ap_rst_n) begin
        m_acc[k] = 0; m_ovfa[k] = 0; f_wr[k] = 0; f_rd[k] = 0;
        e_v[k] = 0; e_d[k] = 0; e_o[k] = 0;
      end else if (ce) begin
        e_v[k] = 0;
        if (f_rd[k] != f_wr[k] && f_due[k][f_rd[k] % 8] == ce_cnt) begin
          e_v[k] = 1;
          e_d[k] = f_d[k][f_rd[k] % 8];
          e_o[k] = f_o[k][f_rd[k] % 8];
          f_rd[k]++;
        end
        if (in_valid) begin
          mw = (k == 1) ? longint'($signed(din1)) : longint'(din1);
          mp = longint'($signed(din0)) * mw;
          if (in_first) begin m_acc[k] = 0; m_ovfa[k] = 0; end
          m_acc[k] += mp;
          if (m_acc[k] > AMAX) begin m_acc[k] = AMAX; m_ovfa[k] = 1; end
          else if (m_acc[k] < AMIN) begin m_acc[k] = AMIN; m_ovfa[k] = 1; end
          if (in_last) begin
            md = m_acc[k];
            mo = m_ovfa[k];
            if (md > DMAX) begin md = DMAX; mo = 1; end
            else if (md < DMIN) begin md = DMIN; mo = 1; end
            f_d[k][f_wr[k] % 8]   = md;
            f_o[k][f_wr[k] % 8]   = mo;
            f_due[k][f_wr[k] % 8] = ce_cnt + ((k == 0) ? NS0 : NS1);
            f_wr[k]++;
          end
        end
      end
    end
  end

  always @(negedge ap_clk) begin
    if (model_on) begin
      check("ref_valid_u", ov0, e_v[0]);
      check("ref_dout_u",  do0, e_d[0]);
      check("ref_ovf_u",   of0, e_o[0]);
      check("ref_valid_s", ov1, e_v[1]);
      check("ref_dout_s",  do1, e_d[1]);
      check("ref_ovf_s",   of1, e_o[1]);
    end
  end

  // Watches both outputs for a window whose last beat was sampled at the previous edge.
  task automatic wait_out(input string name, input longint x0, input bit xo0, input longint x1,
                          input bit xo1, input int lat0, input int lat1, input int st_at, input int st_len);
    int n0, n1, c0, c1;
    logic signed [63:0] g0, g1;
    logic go0, go1;
    n0 = 0; n1 = 0; c0 = 0; c1 = 0; g0 = 0; g1 = 0; go0 = 0; go1 = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge ap_clk);
      if (ov0 === 1'b1) begin
        n0++;
        if (n0 == 1) begin c0 = c; g0 = do0; go0 = of0; end
      end
      if (ov1 === 1'b1) begin
        n1++;
        if (n1 == 1) begin c1 = c; g1 = do1; go1 = of1; end
      end
      if (st_len > 0 && c == st_at) ce = 1'b0;
      if (st_len > 0 && c == st_at + st_len) ce = 1'b1;
    end
    check({name, "_pulses_u"}, n0, 1);
    check({name, "_lat_u"}, c0, lat0);
    check({name, "_dout_u"}, g0, x0);
    check({name, "_ovf_u"}, go0, xo0);
    check({name, "_pulses_s"}, n1, 1);
    check({name, "_lat_s"}, c1, lat1);
    check({name, "_dout_s"}, g1, x1);
    check({name, "_ovf_s"}, go1, xo1);
  endtask

  typedef struct {
    int     d0;
    int     d1;
    bit     f;
    bit     l;
    int     rep;
    longint x0;
    bit     o0;
    longint x1;
    bit     o1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{-8192, 63, 1, 1, 1,  -516096, 0,   8192, 0};
    tbl[1] = '{100,    2, 1, 0, 1,        0, 0,      0, 0};
    tbl[2] = '{-50,    3, 0, 0, 1,        0, 0,      0, 0};
    tbl[3] = '{7,     63, 0, 1, 1,      491, 0,     43, 0};
    tbl[4] = '{8191,  63, 1, 1, 9,   524287, 1, -73719, 0};
    tbl[5] = '{1,      1, 1, 1, 1,        1, 0,      1, 0};
    tbl[6] = '{-8192, 63, 1, 0, 17,       0, 0,      0, 0};
    tbl[7] = '{8191,  63, 0, 1, 16, -132080, 1,   8208, 0};
    tbl[8] = '{100,   63, 1, 1, 1,     6300, 0,   -100, 0};

    ap_rst_n = 1'b0;
    ce       = 1'b1;
    din0     = '0;
    din1     = '0;
    idle();
    repeat (2) tick();
    model_on = 1'b1;
    @(negedge ap_clk);
    check("reset_valid", ov0, 0);
    check("reset_dout", do0, 0);
    check("reset_ovf", of0, 0);
    #1;
    ap_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        beat(tbl[i].d0, tbl[i].d1, tbl[i].f && (r == 0), tbl[i].l && (r == tbl[i].rep - 1));
        tick();
        if (in_last) begin
          idle();
          wait_out($sformatf("vec%0d", i), tbl[i].x0, tbl[i].o0, tbl[i].x1, tbl[i].o1,
                   NS0 + 1, NS1 + 1, 0, 0);
          tick();
        end
      end
    end

    // Stall mid-window with junk on the inputs, then stall again once the last beat is in flight.
    beat(100, 2, 1, 0); tick();
    beat(-50, 3, 0, 0); tick();
    ce = 1'b0;
    beat(999, 17, 1, 1);
    repeat (4) tick();
    ce = 1'b1;
    beat(7, 63, 0, 1); tick();
    idle();
    wait_out("stall", 491, 0, 43, 0, NS0 + 5, NS1 + 5, 1, 4);
    tick();

    // Output holds while ce is low.
    beat(1, 1, 1, 1); tick();
    idle();
    repeat (2) @(negedge ap_clk);
    @(negedge ap_clk);
    check("hold_pre_u", ov0, 1);
    ce = 1'b0;
    repeat (2) begin
      @(negedge ap_clk);
      check("hold_valid_u", ov0, 1);
      check("hold_dout_u", do0, 1);
    end
    ce = 1'b1;
    @(negedge ap_clk);
    check("hold_release_u", ov0, 0);
    repeat (8) tick();

    // Back-to-back single-beat windows.
    beat(5, 5, 1, 1); tick();
    beat(3, 2, 1, 1); tick();
    idle();
    for (int c = 2; c <= 5; c++) begin
      @(negedge ap_clk);
      if (c == 3) begin check("b2b_v1", ov0, 1); check("b2b_d1", do0, 25); end
      if (c == 4) begin check("b2b_v2", ov0, 1); check("b2b_d2", do0, 6); end
      if (c == 5) check("b2b_end", ov0, 0);
    end
    repeat (6) tick();

    // Reset (with ce low) while two beats are in flight.
    beat(9, 9, 1, 0); tick();
    beat(9, 9, 0, 1); tick();
    idle();
    ap_rst_n = 1'b0;
    ce = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    ce = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge ap_clk);
      check("rst_valid_u", ov0, 0);
      check("rst_dout_u", do0, 0);
      check("rst_ovf_u", of0, 0);
      check("rst_valid_s", ov1, 0);
    end
    #1;
    beat(2, 3, 1, 1); tick();
    idle();
    wait_out("post_rst", 6, 0, 6, 0, NS0 + 1, NS1 + 1, 0, 0);
    tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      ce       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_first = ($urandom_range(0, 4) == 0);
      in_last  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       din0 = 14'h1fff;
        1:       din0 = 14'h2000;
        default: din0 = AW'($urandom);
      endcase
      din1     = BW'($urandom);
      ap_rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle();
    ce       = 1'b1;
    ap_rst_n = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
